// File: rtl/d_flip_flop.sv
// Edge-triggered D register with synchronous active-high reset.
// Leaf primitive: Q comes straight from the state register, so there is no path from D or reset to Q.
module d_flip_flop #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Reset is only looked at on the clock edge, so pulses between edges leave Q alone.
  always_ff @(posedge clk) begin
    if (reset) Q <= RESET_VALUE;
    else       Q <= D;
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: default 1-bit instance plus an 8-bit instance with reset value A5.
// A cycle model predicts Q from the sampled inputs; directed literals pin the model.
module tb_d_flip_flop;
  logic       clk = 1'b0;
  logic       run = 1'b0;
  logic       r1, r8;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;
  int total = 0;
  int bad   = 0;

  d_flip_flop u1 (.clk(clk), .reset(r1), .D(d1), .Q(q1));
  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (.clk(clk), .reset(r8), .D(d8), .Q(q8));

  always begin
    #5;
    if (run) clk = ~clk;
  end

  // Model: whatever was present at the last rising edge decides Q until the next one.
  logic       e1;
  logic [7:0] e8;
  bit         mvalid = 0;
  always @(posedge clk) begin
    e1     = (r1 === 1'b1) ? 1'b0  : d1;
    e8     = (r8 === 1'b1) ? 8'hA5 : d8;
    mvalid = 1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      total++;
      if (q1 !== e1) begin
        bad++;
        $display("FAIL model_q1 t=%0t got=%b want=%b", $time, q1, e1);
      end
      total++;
      if (q8 !== e8) begin
        bad++;
        $display("FAIL model_q8 t=%0t got=%h want=%h", $time, q8, e8);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Drive mid-low-phase, then look just after the following rising edge.
  task automatic step(input logic rr1, input logic dd1, input logic rr8, input logic [7:0] dd8);
    @(negedge clk); #2;
    r1 = rr1; d1 = dd1; r8 = rr8; d8 = dd8;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [4:0] seq;
  initial begin
    d1 = 0; r1 = 0; d8 = 8'h00; r8 = 1;
    #100 run = 1;
    @(posedge clk); #1;
    chk("first_edge_q1", {7'b0, q1}, 8'h00);
    chk("first_edge_q8", q8, 8'hA5);
    step(0, 0, 1, 8'h00);
    chk("stays_zero", {7'b0, q1}, 8'h00);

    // Reset wins over D=1 for two edges, then D=1 passes.
    step(1, 1, 1, 8'h00);
    chk("rst_edge1", {7'b0, q1}, 8'h00);
    step(1, 1, 1, 8'h00);
    chk("rst_edge2", {7'b0, q1}, 8'h00);
    step(0, 1, 1, 8'h00);
    chk("rst_release", {7'b0, q1}, 8'h01);

    seq = 5'b01101;  // D = 1,0,1,1,0 applied LSB first
    for (int i = 0; i < 5; i++) begin
      step(0, seq[i], 1, 8'h00);
      chk($sformatf("seq_%0d", i), {7'b0, q1}, {7'b0, seq[i]});
      #2 chk($sformatf("seq_hold_%0d", i), {7'b0, q1}, {7'b0, seq[i]});
    end

    // Reset pulse confined to the high phase must not touch Q.
    step(0, 1, 1, 8'h00);
    chk("pre_pulse", {7'b0, q1}, 8'h01);
    r1 = 1; #2; r1 = 0; #1;
    chk("pulse_between", {7'b0, q1}, 8'h01);
    @(posedge clk); #1;
    chk("pulse_after_edge", {7'b0, q1}, 8'h01);
    step(1, 1, 1, 8'h00);
    chk("pulse_across", {7'b0, q1}, 8'h00);
    step(0, 1, 1, 8'h00);
    chk("resume", {7'b0, q1}, 8'h01);

    // D glitch entirely inside a high phase.
    step(0, 0, 1, 8'h00);
    chk("glitch_base", {7'b0, q1}, 8'h00);
    d1 = 1; #1; d1 = 0; #1;
    chk("glitch_mid", {7'b0, q1}, 8'h00);
    @(posedge clk); #1;
    chk("glitch_after", {7'b0, q1}, 8'h00);

    // X on D propagates.
    step(0, 1'bx, 1, 8'h00);
    chk("x_prop", {7'b0, q1}, {7'b0, 1'bx});
    step(0, 0, 1, 8'h00);
    chk("x_clear", {7'b0, q1}, 8'h00);

    // Wide instance.
    step(0, 0, 1, 8'h5A);
    chk("w_reset", q8, 8'hA5);
    step(0, 0, 0, 8'h3C);
    chk("w_data", q8, 8'h3C);
    step(0, 0, 1, 8'hFF);
    chk("w_rst_prio", q8, 8'hA5);
    step(0, 0, 0, 8'hFF);
    chk("w_resume", q8, 8'hFF);
    step(0, 0, 0, 8'h81);
    chk("w_data2", q8, 8'h81);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
